ir_burst_sequencer: RTL
=======================

IR_BURST_SEQUENCER -- requirements
Module: ir_burst_sequencer

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 8, code ROM address width; DUR_WIDTH, default 16, mark/space duration width; CMP_WIDTH, default 8, carrier compare width; TICK_DIV, default 4, clock cycles per duration unit (>=1).
REQ-002 SHALL have ports (clock and reset first):
- clock_in  in  1  system clock, all state on rising edge.
- reset_in  in  1  reset, asynchronous, active-high.
- start_in  in  1  starts a burst when sampled high in IDLE.
- abort_in  in  1  terminates an active burst.
- code_base_in  in  ADDR_WIDTH  first ROM address of the code.
- pair_count_in  in  ADDR_WIDTH  number of mark/space pairs.
- carrier_in  in  CMP_WIDTH  carrier compare value for the PWM generator.
- rom_addr_out  out  ADDR_WIDTH  code ROM address.
- rom_rd_out  out  1  ROM read strobe.
- rom_data_in  in  2*DUR_WIDTH  {mark, space}, mark in upper half, valid 1 cycle after rom_rd_out.
- pwm_reset_out  out  1  drives PWM generator reset.
- pwm_update_out  out  1  drives PWM generator compare-value write enable.
- pwm_compare_out  out  CMP_WIDTH  drives PWM generator compare value.
- pwm_enable_out  out  1  drives PWM generator enable (carrier on).
- busy_out  out  1  high in every state except IDLE.
- done_out  out  1  one-cycle pulse on normal burst completion.

Function
REQ-003 SHALL implement a Moore FSM with states IDLE, PWM_RST, LOAD, FETCH, WAIT, MARK, SPACE, NEXT, DONE; all outputs decoded from registered state and registers.
REQ-004 In IDLE, start_in high SHALL latch code_base_in, pair_count_in, carrier_in and go to PWM_RST; if latched pair count is 0, go directly to DONE instead.
REQ-005 start_in SHALL be ignored outside IDLE; input changes after latching SHALL not affect the burst.
REQ-006 PWM_RST SHALL last 1 cycle with pwm_reset_out=1, then LOAD.
REQ-007 LOAD SHALL last 1 cycle with pwm_update_out=1 and pwm_compare_out=latched carrier, pwm_enable_out=0, then FETCH.
REQ-008 FETCH SHALL last 1 cycle with rom_rd_out=1 and rom_addr_out=current address; WAIT SHALL last 1 cycle and capture rom_data_in at its end, then MARK.
REQ-009 MARK SHALL hold pwm_enable_out=1 for exactly mark*TICK_DIV cycles; SPACE SHALL hold pwm_enable_out=0 for exactly space*TICK_DIV cycles; a zero duration SHALL skip that state (0 cycles).
REQ-010 The tick prescaler and duration counter SHALL restart on entry to each MARK/SPACE phase.
REQ-011 NEXT SHALL last 1 cycle: decrement remaining pairs; if zero go to DONE, else increment address (modulo 2^ADDR_WIDTH, wrap allowed) and go to FETCH.
REQ-012 DONE SHALL last 1 cycle with done_out=1, then IDLE.
REQ-013 pwm_enable_out SHALL be 1 only in MARK; pwm_compare_out SHALL hold the latched carrier at all times after LOAD.
REQ-014 abort_in high in any non-IDLE state SHALL force IDLE on the next edge: pwm_enable_out=0, no done_out; abort has priority over all transitions; abort_in in IDLE SHALL be ignored and, when coincident with start_in, SHALL suppress the start.

Reset
REQ-015 reset_in high SHALL asynchronously force IDLE and clear all counters and latched values; outputs: rom_addr_out=0, rom_rd_out=0, pwm_reset_out=0, pwm_update_out=0, pwm_compare_out=0, pwm_enable_out=0, busy_out=0, done_out=0.
REQ-016 Reset asserted mid-burst SHALL drop pwm_enable_out immediately (asynchronously); first start after release SHALL behave as from power-up.

Configuration
REQ-017 Macro IR_BURST_REPEAT_EN: when defined, SHALL add input repeat_in (4 bits, latched on start); after the last pair the whole code SHALL replay repeat_in more times from code_base (re-entering FETCH, no PWM_RST/LOAD), then DONE; abort applies across repeats.
REQ-018 When IR_BURST_REPEAT_EN is undefined, repeat_in SHALL not exist and each burst SHALL run exactly once.

Verification
REQ-019 TICK_DIV=4, carrier=25, base=0x10, count=2, ROM[0x10]={3,2}, ROM[0x11]={1,0}, start at cycle 0 -> pwm_reset cycle 1, update(25) cycle 2, reads 0x10/0x11, enable high 12 cycles, low 8, high 4, no space, single done_out pulse.
REQ-020 count=0, start -> busy_out 1 cycle (DONE) with done_out=1, no rom_rd_out, pwm_reset_out or pwm_enable_out activity.
REQ-021 base=0xFF, count=2 -> reads at 0xFF then 0x00.
REQ-022 abort_in asserted 5 cycles into a MARK -> pwm_enable_out 0 next cycle, IDLE, no done_out; start_in during a burst -> ignored.
REQ-023 reset_in asserted mid-MARK, asynchronous to clock -> all outputs reach reset values without a clock edge; new start runs REQ-019 sequence exactly.
REQ-024 With IR_BURST_REPEAT_EN, repeat_in=2, REQ-019 data -> mark/space pattern emitted 3 times, one PWM_RST/LOAD, one done_out.

Source files
------------

// File: rtl/ir_burst_if.sv
// ir_burst_if -- bundle of control, code-ROM and PWM-generator signals for
// ir_burst_sequencer.
//   master : sequencer side (takes start/abort/code parameters and ROM data,
//            drives ROM address/strobe, PWM controls and status)
//   slave  : environment side (host, code ROM, PWM generator)
// When IR_BURST_REPEAT_EN is defined the bundle also carries repeat_in.
interface ir_burst_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DUR_WIDTH  = 16,
    parameter int CMP_WIDTH  = 8
);
    logic                   start_in;
    logic                   abort_in;
    logic [ADDR_WIDTH-1:0]  code_base_in;
    logic [ADDR_WIDTH-1:0]  pair_count_in;
    logic [CMP_WIDTH-1:0]   carrier_in;
`ifdef IR_BURST_REPEAT_EN
    logic [3:0]             repeat_in;
`endif
    logic [ADDR_WIDTH-1:0]  rom_addr_out;
    logic                   rom_rd_out;
    logic [2*DUR_WIDTH-1:0] rom_data_in;
    logic                   pwm_reset_out;
    logic                   pwm_update_out;
    logic [CMP_WIDTH-1:0]   pwm_compare_out;
    logic                   pwm_enable_out;
    logic                   busy_out;
    logic                   done_out;

    modport master (
        input  start_in, abort_in, code_base_in, pair_count_in, carrier_in,
`ifdef IR_BURST_REPEAT_EN
        input  repeat_in,
`endif
        input  rom_data_in,
        output rom_addr_out, rom_rd_out, pwm_reset_out, pwm_update_out,
        output pwm_compare_out, pwm_enable_out, busy_out, done_out
    );

    modport slave (
        output start_in, abort_in, code_base_in, pair_count_in, carrier_in,
`ifdef IR_BURST_REPEAT_EN
        output repeat_in,
`endif
        output rom_data_in,
        input  rom_addr_out, rom_rd_out, pwm_reset_out, pwm_update_out,
        input  pwm_compare_out, pwm_enable_out, busy_out, done_out
    );
endinterface

// File: rtl/ir_burst_sequencer.sv
// ir_burst_sequencer -- plays an IR code stored as {mark, space} duration
// pairs in a code ROM by sequencing a PWM carrier generator.
// Ports:
//   clock_in  - system clock, rising edge
//   reset_in  - asynchronous active-high reset
//   bus       - ir_burst_if.master: start/abort/code_base/pair_count/carrier
//               inputs, ROM address/read strobe/data, PWM reset/update/
//               compare/enable outputs, busy/done status
// Optional feature macro IR_BURST_REPEAT_EN: adds repeat_in (latched on
// start); the whole code is replayed that many extra times from the base
// address before DONE, without re-running PWM_RST/LOAD.
module ir_burst_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DUR_WIDTH  = 16,
    parameter int CMP_WIDTH  = 8,
    parameter int TICK_DIV   = 4
) (
    input  logic     clock_in,
    input  logic     reset_in,
    ir_burst_if.master bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, PWM_RST, LOAD, FETCH, WAIT, MARK, SPACE, NEXT, DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] remain_q;
    logic [CMP_WIDTH-1:0]  carrier_q;
    logic [DUR_WIDTH-1:0]  mark_q, space_q;
    logic [TW-1:0]         tick_q;
    logic [DUR_WIDTH-1:0]  dur_q;
`ifdef IR_BURST_REPEAT_EN
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [3:0]            rep_q;
`endif

    logic                 start_ok;
    logic                 phase_done;
    logic                 last_pair;
    logic                 replay;
    logic [DUR_WIDTH-1:0] dur_sel;

    // Abort in IDLE only suppresses a coincident start.
    assign start_ok  = bus.start_in && !bus.abort_in;
    assign last_pair = (remain_q == ADDR_WIDTH'(1));
`ifdef IR_BURST_REPEAT_EN
    assign replay    = (rep_q != 4'd0);
`else
    assign replay    = 1'b0;
`endif

    // A phase of N units ends on the last tick of the last unit. Zero-length
    // phases are never entered, so dur_sel - 1 cannot underflow here.
    assign dur_sel    = (state_q == MARK) ? mark_q : space_q;
    assign phase_done = (tick_q == TICK_LAST) && (dur_q == dur_sel - DUR_WIDTH'(1));

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d             = state_q;
        bus.rom_addr_out    = addr_q;
        bus.rom_rd_out      = 1'b0;
        bus.pwm_reset_out   = 1'b0;
        bus.pwm_update_out  = 1'b0;
        bus.pwm_compare_out = carrier_q;
        bus.pwm_enable_out  = 1'b0;
        bus.busy_out        = (state_q != IDLE);
        bus.done_out        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok)
                    state_d = (bus.pair_count_in == '0) ? DONE : PWM_RST;
            end
            PWM_RST: begin
                bus.pwm_reset_out = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                bus.pwm_update_out = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                bus.rom_rd_out = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // Skip zero-length phases straight away.
                if (bus.rom_data_in[2*DUR_WIDTH-1:DUR_WIDTH] != '0)
                    state_d = MARK;
                else if (bus.rom_data_in[DUR_WIDTH-1:0] != '0)
                    state_d = SPACE;
                else
                    state_d = NEXT;
            end
            MARK: begin
                bus.pwm_enable_out = 1'b1;
                if (phase_done) state_d = (space_q != '0) ? SPACE : NEXT;
            end
            SPACE: begin
                if (phase_done) state_d = NEXT;
            end
            NEXT: begin
                state_d = (last_pair && !replay) ? DONE : FETCH;
            end
            DONE: begin
                bus.done_out = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && bus.abort_in) state_d = IDLE;
    end

    // Datapath: latched burst parameters, ROM pointer, pair and phase counters.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            addr_q    <= '0;
            remain_q  <= '0;
            carrier_q <= '0;
            mark_q    <= '0;
            space_q   <= '0;
            tick_q    <= '0;
            dur_q     <= '0;
`ifdef IR_BURST_REPEAT_EN
            base_q    <= '0;
            count_q   <= '0;
            rep_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        addr_q    <= bus.code_base_in;
                        remain_q  <= bus.pair_count_in;
                        carrier_q <= bus.carrier_in;
`ifdef IR_BURST_REPEAT_EN
                        base_q    <= bus.code_base_in;
                        count_q   <= bus.pair_count_in;
                        rep_q     <= bus.repeat_in;
`endif
                    end
                end
                WAIT: begin
                    mark_q  <= bus.rom_data_in[2*DUR_WIDTH-1:DUR_WIDTH];
                    space_q <= bus.rom_data_in[DUR_WIDTH-1:0];
                end
                NEXT: begin
`ifdef IR_BURST_REPEAT_EN
                    if (last_pair && replay) begin
                        addr_q   <= base_q;
                        remain_q <= count_q;
                        rep_q    <= rep_q - 4'd1;
                    end else begin
                        addr_q   <= addr_q + ADDR_WIDTH'(1);
                        remain_q <= remain_q - ADDR_WIDTH'(1);
                    end
`else
                    addr_q   <= addr_q + ADDR_WIDTH'(1);
                    remain_q <= remain_q - ADDR_WIDTH'(1);
`endif
                end
                default: ;
            endcase

            // Prescaler and duration counter run only while staying in a
            // MARK/SPACE phase; any state change restarts them from zero.
            if ((state_q == MARK || state_q == SPACE) && state_d == state_q) begin
                if (tick_q == TICK_LAST) begin
                    tick_q <= '0;
                    dur_q  <= dur_q + DUR_WIDTH'(1);
                end else begin
                    tick_q <= tick_q + TW'(1);
                end
            end else begin
                tick_q <= '0;
                dur_q  <= '0;
            end
        end
    end
endmodule
